dm_bytelane: RTL and testbench

DM_BYTELANE -- requirements
Module: dm_bytelane

---
 rtl/dm_bytelane.sv | 185 ++++++++++++++++++
 tb/tb_dm_bytelane.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bytelane.sv
// Byte-lane data memory: zero-fills itself after reset, then serves one load/store
// per cycle with a registered one-cycle response and a store trace.
module dm_bytelane #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 3072
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] clr_idx;
  logic             clr_en;
  logic [31:0]      mem [DEPTH];

  logic [ADDR_W-3:0] word_field;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              illegal;
  logic              accept;
  logic              do_store;
  logic [31:0]       rd_word;
  logic [31:0]       merged;

  logic              vld_p1;
  logic              err_p1;
  logic [31:0]       rdata_p1;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] ln,
                                      input logic in_rng);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = ln[0];
      2'b10:   bad = (ln != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad | ~in_rng;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ln);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001 << ln;
      2'b01:   mask = ln[1] ? 4'b1100 : 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Right-aligned store data is replicated so every lane sees its own copy.
  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] ln);
    logic [31:0] data;
    logic [31:0] res;
    logic [3:0]  mask;
    case (size)
      2'b00:   data = {4{wdata[7:0]}};
      2'b01:   data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    mask = lane_mask(size, ln);
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? data[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] ln, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = signed'(word[{ln, 3'b000} +: 8]);
    h = signed'(word[{ln[1], 4'b0000} +: 16]);
    case (size)
      2'b00:   ext = uns ? signed'({24'b0, b}) : 32'(b);
      2'b01:   ext = uns ? signed'({16'b0, h}) : 32'(h);
      default: ext = signed'(word);
    endcase
    return unsigned'(ext);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_idx == LAST_IDX) begin
      state_nx = RUN;
    end
  end

  // Outputs are qualified by reset so nothing is accepted or cleared on a reset edge.
  always_comb begin
    req_ready = 1'b0;
    clr_en    = 1'b0;
    if (reset) begin
      req_ready = (state == RUN);
      clr_en    = (state == CLEAR);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_idx <= '0;
    end else if (clr_en) begin
      clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
    end
  end

  assign word_field = req_addr[ADDR_W-1:2];
  assign word_idx   = word_field[IDX_W-1:0];
  assign lane       = req_addr[1:0];
  assign in_range   = ({2'b00, word_field} < DEPTH_A);
  assign illegal    = is_illegal(req_size, lane, in_range);
  assign accept     = req_valid & req_ready;
  assign do_store   = accept & ~illegal & req_we;
  assign rd_word    = mem[word_idx];
  assign merged     = merge_store(rd_word, req_wdata, req_size, lane);

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (do_store) begin
      mem[word_idx] <= merged;
    end
  end

  // Stage p1: response registered at the accepting edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= accept;
      err_p1   <= accept & illegal;
      rdata_p1 <= (accept && !illegal && !req_we) ?
                  extend_load(rd_word, req_size, lane, req_unsigned) : '0;
    end
  end

  // A pending response is suppressed while reset is being applied.
  assign rsp_valid = vld_p1 & reset;
  assign rsp_err   = err_p1 & reset;
  assign rsp_rdata = rdata_p1 & {32{reset}};

`ifndef SYNTHESIS
  logic [31:0] trace_addr;
  assign trace_addr = 32'({word_field, 2'b00});

  always_ff @(posedge clk) begin
    if (do_store) begin
      $display("@%h: *%h <= %h", pc, trace_addr, merged);
    end
  end
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Randomized scoreboard bench for dm_bytelane against a byte-array reference model.
module tb_dm_bytelane;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       pc;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  always #5 clk = ~clk;

  dm_bytelane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem [DEPTH*4];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endtask

  // Reference: byte-addressed memory, loads assembled and extended arithmetically.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input string name, output exp_t e);
    int     a;
    int     n;
    longint v;
    a = int'(addr);
    n = 1 << size;
    e.name = name;
    e.err  = 1'b0;
    e.data = 32'h0;
    if (size == 2'b11 || (a % n) != 0 || (a / 4) >= DEPTH) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a+i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[a+i]) << (8*i);
      if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
      e.data = v[31:0];
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input string name);
    exp_t e;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    pc           = $urandom;
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    if (req_ready) begin
      model(we, size, uns, addr, wdata, name, e);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n), 32'(DEPTH));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got valid err=%b data=%h expected no response", rsp_err, rsp_rdata);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
        check({e.name, "_data"}, rsp_rdata, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]        sz;
    logic [ADDR_W-1:0] ad;
    int                r;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; pc = '0;

    // Reset held for two edges, then the clear sequence.
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    clear_model();
    reset = 1'b1;
    wait_ready("clear_edges");
    issue(0, 2'b10, 0, 14'h3C, 0, "clr_lw3c");
    idle(2);

    // Byte/half merge into one word.
    issue(1, 2'b10, 0, 14'h0, 32'h11223344, "sw0");
    issue(1, 2'b00, 0, 14'h2, 32'h000000AB, "sb2");
    issue(1, 2'b01, 0, 14'h0, 32'h0000BEEF, "sh0");
    issue(0, 2'b10, 0, 14'h0, 0, "lw0");
    idle(1);

    // Load extension.
    issue(1, 2'b10, 0, 14'h4, 32'h80FF7F01, "sw4");
    issue(0, 2'b00, 0, 14'h5, 0, "lb5");
    issue(0, 2'b00, 1, 14'h5, 0, "lbu5");
    issue(0, 2'b00, 0, 14'h4, 0, "lb4");
    issue(0, 2'b01, 0, 14'h6, 0, "lh6");
    issue(0, 2'b01, 1, 14'h6, 0, "lhu6");
    idle(1);

    // Rejected requests leave memory intact.
    issue(1, 2'b01, 0, 14'h1, 32'hFFFFFFFF, "err_sh1");
    issue(1, 2'b10, 0, 14'h2, 32'hFFFFFFFF, "err_sw2");
    issue(1, 2'b11, 0, 14'h0, 32'hFFFFFFFF, "err_size3");
    issue(1, 2'b10, 0, 14'(DEPTH*4), 32'hFFFFFFFF, "err_oob");
    issue(0, 2'b10, 0, 14'h0, 0, "lw0_after_err");
    issue(0, 2'b10, 0, 14'h4, 0, "lw4_after_err");
    idle(1);

    // Back-to-back store then load of the same word.
    issue(1, 2'b10, 0, 14'h8, 32'hCAFEF00D, "b2b_sw8");
    issue(0, 2'b10, 0, 14'h8, 0, "b2b_lw8");
    idle(2);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        r  = $urandom_range(0, 9);
        sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        if ($urandom_range(0, 9) == 0) ad = 14'($urandom_range(0, 2**ADDR_W - 1));
        else ad = 14'($urandom_range(0, DEPTH*4 - 1));
        if ($urandom_range(0, 4) != 0) ad = ad & ~14'((1 << sz) - 1);
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
              $sformatf("rnd%0d", k));
      end
    end
    idle(2);

    // Reset in the cycle after a load accept drops the response.
    issue(0, 2'b10, 0, 14'h8, 0, "pre_rst_lw");
    reset = 1'b0;
    req_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_drops_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_model();
    reset = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("midclear_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    wait_ready("clear_restart_edges");
    for (int w = 0; w < DEPTH; w++) issue(0, 2'b10, 0, 14'(4*w), 0, $sformatf("post_clr_lw%0d", w));
    idle(3);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
